// File: rtl/mem_init_gen.sv
// mem_init_gen: parametrised RAM initialiser, one write per clock.
// Optional read-back check of the written words with INIT_VERIFY_EN.
module mem_init_gen #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] stride,
`ifdef INIT_VERIFY_EN
  input  logic [DATA_W-1:0] rddata,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
`endif
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] REV0 = DATA_W'(DEPTH - 1);

  localparam logic [1:0] M_ID   = 2'b00;
  localparam logic [1:0] M_FILL = 2'b01;
  localparam logic [1:0] M_RAMP = 2'b10;
  localparam logic [1:0] M_REV  = 2'b11;

`ifdef INIT_VERIFY_EN
  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY_RD,
    VERIFY_CHK
  } state_t;
`else
  typedef enum logic {
    IDLE,
    WRITE
  } state_t;
`endif

  state_t state;
  state_t state_d;

  logic              rdy_d;
  logic              wren_d;
  logic              done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wrdata_d;

  logic [1:0]        mode_q;
  logic [1:0]        mode_d;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] seed_d;
  logic [DATA_W-1:0] stride_q;
  logic [DATA_W-1:0] stride_d;

  logic [ADDR_W-1:0] addr_inc;
  logic              at_last;

`ifdef INIT_VERIFY_EN
  logic              err_d;
  logic [ADDR_W-1:0] err_addr_d;
  logic              chk_vld;
  logic              chk_vld_d;
  logic [DATA_W-1:0] chk_exp;
  logic [DATA_W-1:0] chk_exp_d;
  logic [ADDR_W-1:0] chk_idx;
  logic [ADDR_W-1:0] chk_idx_d;
`endif

  // Pattern value for index 0 of a run.
  function automatic logic [DATA_W-1:0] pat_first(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s
  );
    logic [DATA_W-1:0] v;
    v = '0;
    unique case (m)
      M_ID:   v = '0;
      M_FILL: v = s;
      M_RAMP: v = s;
      M_REV:  v = REV0;
    endcase
    return v;
  endfunction

  // Pattern value for index idx, given the value at idx-1.
  // Ramp is an accumulator so no multiplier is needed.
  function automatic logic [DATA_W-1:0] pat_next(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [DATA_W-1:0] st,
    input logic [DATA_W-1:0] cur,
    input logic [ADDR_W-1:0] idx
  );
    logic [DATA_W-1:0] v;
    v = '0;
    unique case (m)
      M_ID:   v = DATA_W'(idx);
      M_FILL: v = s;
      M_RAMP: v = cur + st;
      M_REV:  v = REV0 - DATA_W'(idx);
    endcase
    return v;
  endfunction

  // addr_inc is only consumed when addr != LAST, so it never wraps.
  assign addr_inc = addr + ADDR_W'(1);
  assign at_last  = (addr == LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    rdy_d    = rdy;
    wren_d   = wren;
    addr_d   = addr;
    wrdata_d = wrdata;
    done_d   = 1'b0;
    mode_d   = mode_q;
    seed_d   = seed_q;
    stride_d = stride_q;
`ifdef INIT_VERIFY_EN
    err_d      = err;
    err_addr_d = err_addr;
    chk_vld_d  = 1'b0;
    chk_exp_d  = chk_exp;
    chk_idx_d  = chk_idx;
    if (chk_vld && !err && (rddata != chk_exp)) begin
      err_d      = 1'b1;
      err_addr_d = chk_idx;
    end
`endif
    unique case (state)
      IDLE: begin
        if (en && rdy) begin
          mode_d   = mode;
          seed_d   = seed;
          stride_d = stride;
          rdy_d    = 1'b0;
          wren_d   = 1'b1;
          addr_d   = '0;
          wrdata_d = pat_first(mode, seed);
          state_d  = WRITE;
`ifdef INIT_VERIFY_EN
          err_d      = 1'b0;
          err_addr_d = '0;
`endif
        end
      end
      WRITE: begin
        if (at_last) begin
          wren_d = 1'b0;
          addr_d = '0;
`ifdef INIT_VERIFY_EN
          wrdata_d = pat_first(mode_q, seed_q);
          state_d  = VERIFY_RD;
`else
          rdy_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          addr_d   = addr_inc;
          wrdata_d = pat_next(mode_q, seed_q, stride_q,
                              wrdata, addr_inc);
        end
      end
`ifdef INIT_VERIFY_EN
      VERIFY_RD: begin
        chk_vld_d = 1'b1;
        chk_exp_d = wrdata;
        chk_idx_d = addr;
        if (at_last) begin
          addr_d  = '0;
          state_d = VERIFY_CHK;
        end else begin
          addr_d   = addr_inc;
          wrdata_d = pat_next(mode_q, seed_q, stride_q,
                              wrdata, addr_inc);
        end
      end
      VERIFY_CHK: begin
        rdy_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
    endcase
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy      <= 1'b1;
      wren     <= 1'b0;
      addr     <= '0;
      wrdata   <= '0;
      done     <= 1'b0;
      mode_q   <= '0;
      seed_q   <= '0;
      stride_q <= '0;
`ifdef INIT_VERIFY_EN
      err      <= 1'b0;
      err_addr <= '0;
      chk_vld  <= 1'b0;
      chk_exp  <= '0;
      chk_idx  <= '0;
`endif
    end else begin
      state    <= state_d;
      rdy      <= rdy_d;
      wren     <= wren_d;
      addr     <= addr_d;
      wrdata   <= wrdata_d;
      done     <= done_d;
      mode_q   <= mode_d;
      seed_q   <= seed_d;
      stride_q <= stride_d;
`ifdef INIT_VERIFY_EN
      err      <= err_d;
      err_addr <= err_addr_d;
      chk_vld  <= chk_vld_d;
      chk_exp  <= chk_exp_d;
      chk_idx  <= chk_idx_d;
`endif
    end
  end

endmodule
